// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 definitions for the F-extension FPU FSMs.
//   state_e  - sequencing states of the multi-cycle FPU units
//   EXP_BIAS, EXP_W, FRAC_W, QNAN, POS_INF - binary32 format constants
//   is_nan / is_inf / is_zero - operand classification (exponent 0 is
//   treated as zero, so denormals are flushed)
package fpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_CHECK,
      S_DIVIDE,
      S_NORM,
      S_PACK,
      S_DONE
   } state_e;

   localparam int          EXP_BIAS = 127;
   localparam int          EXP_W    = 8;
   localparam int          FRAC_W   = 23;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF  = 32'h7F80_0000;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != '0);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == '0);
   endfunction

   function automatic logic is_zero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

endpackage

// File: rtl/fpu_mant_div.sv
// fpu_mant_div: bit-serial restoring mantissa divider, one quotient bit
// per step.
//   clk, rst_n - clock, async active-low reset
//   load_i     - rem <= M1, q <= 0, counter <= 0
//   step_i     - one restoring iteration
//   m1_i, m2_i - 24-bit mantissas with hidden bit; m2_i held by caller
//   q_o        - 25-bit quotient, floor(M1 * 2^24 / M2) after 25 steps
//   last_o     - the step now in progress is the 25th
module fpu_mant_div (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [23:0] m1_i,
   input  logic [23:0] m2_i,
   output logic [24:0] q_o,
   output logic        last_o
);

   logic [25:0] rem_q, rem_d, diff;
   logic [24:0] q_q, q_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ge;

   always_comb begin
      ge    = rem_q >= {2'b00, m2_i};
      diff  = ge ? (rem_q - {2'b00, m2_i}) : rem_q;
      rem_d = rem_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      if (load_i) begin
         rem_d = {2'b00, m1_i};
         q_d   = '0;
         cnt_d = '0;
      end else if (step_i) begin
         // partial remainder stays below 2*M2, so the shift never overflows 26 bits
         rem_d = diff << 1;
         q_d   = {q_q[23:0], ge};
         cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q_o    = q_q;
   assign last_o = cnt_q == 5'd24;

endmodule

// File: rtl/div_fpu_fsm.sv
// div_fpu_fsm: multi-cycle binary32 divider, truncating, denormals flushed.
//   clk, rst_n - clock, async active-low reset
//   start      - request, sampled in IDLE (and holds DONE while high)
//   N1, N2     - dividend, divisor
//   result     - quotient, valid while done
//   done       - high in DONE
//   busy       - high from UNPACK through PACK
//   dz, nv     - divide-by-zero / invalid flags, valid with done
module div_fpu_fsm
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] N1,
   input  logic [31:0] N2,
   output logic [31:0] result,
   output logic        done,
   output logic        busy,
   output logic        dz,
   output logic        nv
);

   state_e            state_q, state_d;
   logic [31:0]       n1_q, n1_d, n2_q, n2_d;
   logic              sign_q, sign_d;
   logic [EXP_W-1:0]  e1_q, e1_d, e2_q, e2_d;
   logic [23:0]       m1_q, m1_d, m2_q, m2_d;
   logic              spec_q, spec_d;
   logic [FRAC_W-1:0] frac_q, frac_d;
   logic signed [9:0] exp_q, exp_d;
   logic [31:0]       res_q, res_d;
   logic              dz_q, dz_d, nv_q, nv_d, done_q, done_d, busy_q, busy_d;
   logic              div_load, div_step, div_last;
   logic [24:0]       div_q;
   logic [31:0]       inf_s, zero_s;

   fpu_mant_div u_mant_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (div_load),
      .step_i (div_step),
      .m1_i   (m1_q),
      .m2_i   (m2_q),
      .q_o    (div_q),
      .last_o (div_last)
   );

   assign inf_s  = POS_INF | {sign_q, 31'd0};
   assign zero_s = {sign_q, 31'd0};

   always_comb begin
      state_d  = state_q;
      n1_d     = n1_q;
      n2_d     = n2_q;
      sign_d   = sign_q;
      e1_d     = e1_q;
      e2_d     = e2_q;
      m1_d     = m1_q;
      m2_d     = m2_q;
      spec_d   = spec_q;
      frac_d   = frac_q;
      exp_d    = exp_q;
      res_d    = res_q;
      dz_d     = dz_q;
      nv_d     = nv_q;
      div_load = 1'b0;
      div_step = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_UNPACK;
               n1_d    = N1;
               n2_d    = N2;
               dz_d    = 1'b0;
               nv_d    = 1'b0;
            end
         end
         S_UNPACK: begin
            sign_d  = n1_q[31] ^ n2_q[31];
            e1_d    = n1_q[30:23];
            e2_d    = n2_q[30:23];
            m1_d    = {1'b1, n1_q[22:0]};
            m2_d    = {1'b1, n2_q[22:0]};
            state_d = S_CHECK;
         end
         S_CHECK: begin
            // special results are written to res_q now; PACK leaves them alone
            spec_d  = 1'b1;
            state_d = S_PACK;
            if (is_nan(n1_q) || is_nan(n2_q)) begin
               res_d = QNAN;
               nv_d  = 1'b1;
            end else if ((is_zero(n1_q) && is_zero(n2_q)) ||
                         (is_inf(n1_q) && is_inf(n2_q))) begin
               res_d = QNAN;
               nv_d  = 1'b1;
            end else if (is_zero(n2_q) && !is_inf(n1_q)) begin
               res_d = inf_s;
               dz_d  = 1'b1;
            end else if (is_inf(n1_q)) begin
               res_d = inf_s;
            end else if (is_zero(n1_q) || is_inf(n2_q)) begin
               res_d = zero_s;
            end else begin
               spec_d   = 1'b0;
               div_load = 1'b1;
               state_d  = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            div_step = 1'b1;
            if (div_last) state_d = S_NORM;
         end
         S_NORM: begin
            // quotient in (0.5, 2): bit 24 set means the integer bit is 1
            if (div_q[24]) begin
               frac_d = div_q[23:1];
               exp_d  = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'(EXP_BIAS);
            end else begin
               frac_d = div_q[22:0];
               exp_d  = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'(EXP_BIAS - 1);
            end
            state_d = S_PACK;
         end
         S_PACK: begin
            if (!spec_q) begin
               if (exp_q >= 10'sd255)     res_d = inf_s;
               else if (exp_q <= 10'sd0)  res_d = zero_s;
               else                       res_d = {sign_q, exp_q[7:0], frac_q};
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = state_d == S_DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n1_q    <= '0;
         n2_q    <= '0;
         sign_q  <= 1'b0;
         e1_q    <= '0;
         e2_q    <= '0;
         m1_q    <= '0;
         m2_q    <= '0;
         spec_q  <= 1'b0;
         frac_q  <= '0;
         exp_q   <= '0;
         res_q   <= '0;
         dz_q    <= 1'b0;
         nv_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n1_q    <= n1_d;
         n2_q    <= n2_d;
         sign_q  <= sign_d;
         e1_q    <= e1_d;
         e2_q    <= e2_d;
         m1_q    <= m1_d;
         m2_q    <= m2_d;
         spec_q  <= spec_d;
         frac_q  <= frac_d;
         exp_q   <= exp_d;
         res_q   <= res_d;
         dz_q    <= dz_d;
         nv_q    <= nv_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign result = res_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign dz     = dz_q;
   assign nv     = nv_q;

endmodule
